// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO block with registered LED outputs, synchronised
// switch inputs, rising-edge status capture and a level interrupt.
//
// Optional build macro: GPIO_DEBOUNCE_EN adds a per-bit stability counter
// (DEB_CYCLES edges) between the synchroniser and the IN register.
//
// Ports:
//   clk           - sole clock, rising edge
//   reset         - asynchronous active-low reset
//   Adr_in        - bus address; [31:16] must equal BASE_HI for a hit
//   Data_in       - bus write data; only [WIDTH-1:0] is used
//   we_in         - write strobe, qualified per cycle
//   gpio_port_in  - switch pins, asynchronous to clk
//   Data_out      - read data, combinational from Adr_in, zero-extended
//   gpio_port_out - LED pins (OUT register)
//   set_leds      - one-cycle pulse after an accepted OUT write
//   irq           - |(IRQ_STAT & IRQ_EN)
//
// Register offsets (Adr_in[15:0]): 0x0024 OUT, 0x0028 IN, 0x002C IRQ_EN,
// 0x0030 IRQ_STAT (write-1-to-clear).
module gpio_bank #(
  parameter int          WIDTH      = 8,
  parameter logic [15:0] BASE_HI    = 16'h1001,
  parameter int          DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Adr_in,
  input  logic [31:0]      Data_in,
  input  logic             we_in,
  input  logic [WIDTH-1:0] gpio_port_in,
  output logic [31:0]      Data_out,
  output logic [WIDTH-1:0] gpio_port_out,
  output logic             set_leds,
  output logic             irq
);

  localparam logic [15:0] OFF_OUT  = 16'h0024;
  localparam logic [15:0] OFF_IN   = 16'h0028;
  localparam logic [15:0] OFF_IEN  = 16'h002C;
  localparam logic [15:0] OFF_STAT = 16'h0030;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             set_leds_q, set_leds_d;
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic             hit;
  logic             wr_out, wr_ien, wr_stat;

  // Only the low WIDTH bits of write data are architecturally used.
  logic unused_data;
  assign unused_data = ^Data_in;

  // Two-flop synchroniser per bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_port_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [WIDTH-1:0]      filt_q, filt_d;
  logic [WIDTH-1:0][7:0] cnt_q, cnt_d;

  // The filtered bit follows the synchronised bit only after it has differed
  // for DEB_CYCLES consecutive edges; agreeing again restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == 8'(DEB_CYCLES - 1)) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_val = filt_q;
`else
  localparam int DEB_CYCLES_UNUSED = DEB_CYCLES;
  assign in_val = sync2_q;
`endif

  // Bus decode and register next-state.
  always_comb begin
    hit     = (Adr_in[31:16] == BASE_HI);
    wdata   = Data_in[WIDTH-1:0];
    wr_out  = we_in && hit && (Adr_in[15:0] == OFF_OUT);
    wr_ien  = we_in && hit && (Adr_in[15:0] == OFF_IEN);
    wr_stat = we_in && hit && (Adr_in[15:0] == OFF_STAT);

    // prev_q resets to 0, so a pin held high through reset still reports a rise.
    rise   = in_val & ~prev_q;
    prev_d = in_val;

    out_d      = wr_out ? wdata : out_q;
    ien_d      = wr_ien ? wdata : ien_q;
    set_leds_d = wr_out;

    // A rise on the same edge as its W1C leaves the bit set.
    stat_d = (stat_q & ~(wr_stat ? wdata : '0)) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q      <= '0;
      ien_q      <= '0;
      stat_q     <= '0;
      prev_q     <= '0;
      set_leds_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      ien_q      <= ien_d;
      stat_q     <= stat_d;
      prev_q     <= prev_d;
      set_leds_q <= set_leds_d;
    end
  end

  // Read mux: zero on any non-hit or unmapped offset.
  always_comb begin
    Data_out = '0;
    if (hit) begin
      case (Adr_in[15:0])
        OFF_OUT:  Data_out = 32'(out_q);
        OFF_IN:   Data_out = 32'(in_val);
        OFF_IEN:  Data_out = 32'(ien_q);
        OFF_STAT: Data_out = 32'(stat_q);
        default:  Data_out = '0;
      endcase
    end
  end

  assign gpio_port_out = out_q;
  assign set_leds      = set_leds_q;
  assign irq           = |(stat_q & ien_q);

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;

  localparam logic [31:0] A_OUT  = 32'h1001_0024;
  localparam logic [31:0] A_IN   = 32'h1001_0028;
  localparam logic [31:0] A_IEN  = 32'h1001_002C;
  localparam logic [31:0] A_STAT = 32'h1001_0030;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Adr_in;
  logic [31:0] Data_in;
  logic        we_in;
  logic [7:0]  gpio_port_in;
  logic [31:0] Data_out;
  logic [7:0]  gpio_port_out;
  logic        set_leds;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  gpio_bank #(.WIDTH(8), .BASE_HI(16'h1001), .DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .Adr_in(Adr_in), .Data_in(Data_in), .we_in(we_in),
    .gpio_port_in(gpio_port_in), .Data_out(Data_out), .gpio_port_out(gpio_port_out),
    .set_leds(set_leds), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one bus write; returns 1 time unit after the accepting edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    Adr_in = a; Data_in = d; we_in = 1'b1;
    tick();
    we_in = 1'b0; Adr_in = '0; Data_in = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; we_in = 1'b0; Adr_in = '0; Data_in = '0; gpio_port_in = '0;
    tick();
    n_vec++; if (gpio_port_out !== 8'h00) begin n_err++; $display("FAIL rst_out got %h exp 00", gpio_port_out); end
    n_vec++; if (set_leds !== 1'b0) begin n_err++; $display("FAIL rst_setleds got %b exp 0", set_leds); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b exp 0", irq); end
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL rst_stat got %h exp 0", Data_out); end
    Adr_in = '0;
    reset = 1'b1;
  endtask

  task automatic test_debounce();
`ifdef GPIO_DEBOUNCE_EN
    gpio_port_in = 8'h04;
    repeat (3) tick();
    gpio_port_in = 8'h00;
    repeat (10) tick();
    Adr_in = A_IN; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL deb_short_in got %h exp 0", Data_out); end
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL deb_short_stat got %h exp 0", Data_out); end
    gpio_port_in = 8'h04;
    repeat (5) tick();
    Adr_in = A_IN; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL deb_edge5 got %h exp 0", Data_out); end
    tick();
    Adr_in = A_IN; #1;
    n_vec++; if (Data_out !== 32'h4) begin n_err++; $display("FAIL deb_edge6 got %h exp 4", Data_out); end
    gpio_port_in = 8'h00;
    tick();
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h4) begin n_err++; $display("FAIL deb_stat got %h exp 4", Data_out); end
    repeat (10) tick();
    do_write(A_STAT, 32'h4);
`endif
  endtask

  task automatic test_out_write();
    do_write(A_OUT, 32'h0000_00A5);
    n_vec++; if (gpio_port_out !== 8'hA5) begin n_err++; $display("FAIL out_val got %h exp a5", gpio_port_out); end
    n_vec++; if (set_leds !== 1'b1) begin n_err++; $display("FAIL setleds_hi got %b exp 1", set_leds); end
    Adr_in = A_OUT; #1;
    n_vec++; if (Data_out !== 32'h0000_00A5) begin n_err++; $display("FAIL out_read got %h exp a5", Data_out); end
    tick();
    n_vec++; if (set_leds !== 1'b0) begin n_err++; $display("FAIL setleds_lo got %b exp 0", set_leds); end
    Adr_in = 32'h1001_0040; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL unmapped_read got %h exp 0", Data_out); end
    Adr_in = 32'h1002_0024; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL base_miss_read got %h exp 0", Data_out); end
  endtask

  task automatic test_no_hit();
    do_write(32'h1002_0024, 32'hFFFF_FFFF);
    n_vec++; if (set_leds !== 1'b0) begin n_err++; $display("FAIL nohit_base_sl got %b exp 0", set_leds); end
    n_vec++; if (gpio_port_out !== 8'hA5) begin n_err++; $display("FAIL nohit_base_out got %h exp a5", gpio_port_out); end
    do_write(A_IN, 32'hFFFF_FFFF);
    n_vec++; if (set_leds !== 1'b0) begin n_err++; $display("FAIL nohit_in_sl got %b exp 0", set_leds); end
    n_vec++; if (gpio_port_out !== 8'hA5) begin n_err++; $display("FAIL nohit_in_out got %h exp a5", gpio_port_out); end
    Adr_in = A_IN; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL nohit_in_read got %h exp 0", Data_out); end
    do_write(32'h1001_0040, 32'hFFFF_FFFF);
    Adr_in = A_IEN; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL nohit_ien got %h exp 0", Data_out); end
  endtask

  task automatic test_irq();
    do_write(A_IEN, 32'hFFFF_FF01);
    Adr_in = A_IEN; #1;
    n_vec++; if (Data_out !== 32'h1) begin n_err++; $display("FAIL ien_read got %h exp 1", Data_out); end
    gpio_port_in = 8'h81;
    repeat (LAT - 1) tick();
    Adr_in = A_IN; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL in_early got %h exp 0", Data_out); end
    tick();
    Adr_in = A_IN; #1;
    n_vec++; if (Data_out !== 32'h81) begin n_err++; $display("FAIL in_val got %h exp 81", Data_out); end
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL stat_early got %h exp 0", Data_out); end
    tick();
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h81) begin n_err++; $display("FAIL stat_set got %h exp 81", Data_out); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hi got %b exp 1", irq); end
    do_write(A_STAT, 32'h1);
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h80) begin n_err++; $display("FAIL stat_w1c got %h exp 80", Data_out); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_lo got %b exp 0", irq); end
    gpio_port_in = 8'h00;
    repeat (LAT + 3) tick();
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h80) begin n_err++; $display("FAIL fall_stat got %h exp 80", Data_out); end
    do_write(A_STAT, 32'h80);
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL stat_clr got %h exp 0", Data_out); end
  endtask

  task automatic test_w1c_collision();
    gpio_port_in = 8'h01;
    repeat (LAT) tick();
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL coll_pre got %h exp 0", Data_out); end
    do_write(A_STAT, 32'h1);
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h1) begin n_err++; $display("FAIL coll_stat got %h exp 1", Data_out); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL coll_irq got %b exp 1", irq); end
  endtask

  task automatic test_reset_mid();
    gpio_port_in = 8'h0F;
    repeat (LAT + 1) tick();
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h0F) begin n_err++; $display("FAIL mid_stat got %h exp 0f", Data_out); end
    do_write(A_OUT, 32'hFF);
    n_vec++; if (gpio_port_out !== 8'hFF) begin n_err++; $display("FAIL mid_out got %h exp ff", gpio_port_out); end
    #1 reset = 1'b0;
    Adr_in = A_STAT; #1;
    n_vec++; if (gpio_port_out !== 8'h00) begin n_err++; $display("FAIL arst_out got %h exp 00", gpio_port_out); end
    n_vec++; if (set_leds !== 1'b0) begin n_err++; $display("FAIL arst_sl got %b exp 0", set_leds); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL arst_irq got %b exp 0", irq); end
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL arst_stat got %h exp 0", Data_out); end
    Adr_in = A_OUT; Data_in = 32'h3C; we_in = 1'b1;
    tick();
    we_in = 1'b0;
    n_vec++; if (gpio_port_out !== 8'h00) begin n_err++; $display("FAIL rst_write got %h exp 00", gpio_port_out); end
    reset = 1'b1;
    repeat (LAT + 1) tick();
    Adr_in = A_STAT; #1;
    n_vec++; if (Data_out !== 32'h0F) begin n_err++; $display("FAIL post_rst_stat got %h exp 0f", Data_out); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL post_rst_irq got %b exp 0", irq); end
    Adr_in = A_OUT; #1;
    n_vec++; if (Data_out !== 32'h0) begin n_err++; $display("FAIL post_rst_out got %h exp 0", Data_out); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_out_write();
    test_no_hit();
    test_irq();
    test_w1c_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter WIDTH, default 8, port width in bits; legal range 1..32.
REQ-002 Parameter BASE_HI, default 16'h1001, required value of Adr_in[31:16] for any register hit.
REQ-003 Parameter DEB_CYCLES, default 4, debounce stability count; legal range 1..255; used only with GPIO_DEBOUNCE_EN.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 Adr_in  input  32  bus address.
REQ-007 Data_in  input  32  bus write data.
REQ-008 we_in  input  1  write strobe, one-cycle qualified.
REQ-009 gpio_port_in  input  WIDTH  switch pins, asynchronous to clk.
REQ-010 Data_out  output  32  read data, combinational from Adr_in.
REQ-011 gpio_port_out  output  WIDTH  LED pins, registered.
REQ-012 set_leds  output  1  one-cycle pulse following an accepted OUT write.
REQ-013 irq  output  1  level interrupt.

Function
REQ-014 Register map: hit requires Adr_in[31:16]==BASE_HI; offsets Adr_in[15:0]: 0x0024 OUT (R/W), 0x0028 IN (RO), 0x002C IRQ_EN (R/W), 0x0030 IRQ_STAT (R/W1C).
REQ-015 Write accepted on a clk edge with we_in=1 and a hit; bits [WIDTH-1:0] of Data_in used, upper bits ignored.
REQ-016 OUT write: gpio_port_out equals the new value from the edge of acceptance; set_leds=1 for exactly the following cycle.
REQ-017 Writes to IN, to unmapped offsets, or with BASE_HI mismatch change no state.
REQ-018 Data_out: selected register zero-extended to 32 bits; 0 on any non-hit; IN reads return the filtered input value.
REQ-019 Input path: gpio_port_in passes through a 2-flop synchroniser per bit; a pin change is visible in IN 2 edges later (without debounce).
REQ-020 Edge detect: a 0->1 transition of a filtered bit sets IRQ_STAT[bit] on the next edge, independent of IRQ_EN.
REQ-021 IRQ_STAT write: each 1 bit clears that bit; 0 bits have no effect.
REQ-022 Same-edge set event and W1C clear on one bit: set wins, bit remains 1.
REQ-023 irq = |(IRQ_STAT & IRQ_EN), combinational from registers; no glitch from Adr_in.
REQ-024 Falling edges never set status.

Reset
REQ-025 reset low asynchronously forces: OUT=0, IRQ_EN=0, IRQ_STAT=0, synchroniser and filter stages=0, set_leds=0; hence gpio_port_out=0, irq=0.
REQ-026 Reset deassertion mid-operation: first edge detect is evaluated against the reset value 0, so a pin held high through reset sets IRQ_STAT after it propagates.
REQ-027 A write coincident with reset assertion is discarded.

Configuration
REQ-028 Macro GPIO_DEBOUNCE_EN defined: each synchronised bit has an 8-bit counter; the filtered bit takes the new value only after the synchronised value differs from it for DEB_CYCLES consecutive edges; any return to the filtered value resets the counter to 0.
REQ-029 With GPIO_DEBOUNCE_EN, pin-to-IN latency is 2+DEB_CYCLES edges; pulses shorter than DEB_CYCLES cycles are suppressed entirely.
REQ-030 Macro undefined: filtered bit equals synchronised bit; no counters synthesised.

Verification
REQ-031 Reset, then write 0x000000A5 to 0x10010024 -> gpio_port_out=8'hA5 after the edge, set_leds high exactly one cycle, read of 0x10010024 returns 0x000000A5.
REQ-032 Write 0xFFFFFFFF to 0x10020024 and to 0x10010028 -> gpio_port_out unchanged, set_leds stays 0.
REQ-033 gpio_port_in 0x00->0x81, IRQ_EN=0x01 -> IN reads 0x81 after 2 edges (no debounce), IRQ_STAT=0x81, irq=1; write 0x01 to 0x10010030 -> IRQ_STAT=0x80, irq=0.
REQ-034 Bit 0 rises on the same edge as a W1C of 0x01 -> IRQ_STAT[0] stays 1.
REQ-035 GPIO_DEBOUNCE_EN, DEB_CYCLES=4: 3-cycle high pulse on bit 2 -> IN and IRQ_STAT unchanged; 6-cycle high pulse -> IN[2]=1 at edge 6 after the pulse starts.
REQ-036 Assert reset mid-operation with OUT=0xFF, IRQ_STAT=0x0F -> all outputs 0 immediately, before the next clk edge.
